// File: rtl/blue_sequencer.sv
// Command sequencer that iterates a combinational ALU cmd_rpt+1 times per command
// and then holds the final operands and flags until the consumer takes them.
module blue_sequencer #(
  parameter int REPEAT_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [15:0]         cmd_op,
  input  logic [15:0]         cmd_a,
  input  logic [15:0]         cmd_b,
  input  logic [REPEAT_W-1:0] cmd_rpt,
  output logic [15:0]         alu_op,
  output logic [15:0]         alu_a,
  output logic [15:0]         alu_b,
  output logic [2:0]          alu_znc_in,
  input  logic [15:0]         alu_a_res,
  input  logic [15:0]         alu_b_res,
  input  logic [2:0]          alu_znc,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [15:0]         res_a,
  output logic [15:0]         res_b,
  output logic [2:0]          res_znc,
  output logic                busy
);

  // state  | meaning
  // S_IDLE | waiting for a command, cmd_ready high
  // S_EXEC | one ALU iteration per clock, r_cnt iterations left after this one
  // S_DONE | result presented, waiting for res_ready
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_accept;
  logic                w_exec;
  logic [15:0]         r_op;
  logic [15:0]         r_a;
  logic [15:0]         r_b;
  logic [2:0]          r_flags;
  logic [REPEAT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_exec      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        w_exec = 1'b1;
        if (r_cnt == '0) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (res_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Counter is tested for zero before decrementing, so the all-ones repeat
  // count gives 2^REPEAT_W iterations without wrapping. Flags survive
  // between commands so carries can chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_flags <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_op  <= cmd_op;
      r_a   <= cmd_a;
      r_b   <= cmd_b;
      r_cnt <= cmd_rpt;
    end else if (w_exec) begin
      r_a     <= alu_a_res;
      r_b     <= alu_b_res;
      r_flags <= alu_znc;
      if (r_cnt != '0) r_cnt <= r_cnt - REPEAT_W'(1);
    end
  end

  assign cmd_ready  = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign res_valid  = (r_state == S_DONE);
  assign alu_op     = r_op;
  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign alu_znc_in = r_flags;
  assign res_a      = r_a;
  assign res_b      = r_b;
  assign res_znc    = r_flags;

endmodule

// File: tb/tb_blue_sequencer.sv
// Bench for blue_sequencer: adder ALU stub, directed commands followed by random
// commands, all compared against closed-form expected results.
module tb_blue_sequencer;
  localparam int REPEAT_W = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                cmd_valid = 1'b0;
  logic                cmd_ready;
  logic [15:0]         cmd_op = '0;
  logic [15:0]         cmd_a = '0;
  logic [15:0]         cmd_b = '0;
  logic [REPEAT_W-1:0] cmd_rpt = '0;
  logic [15:0]         alu_op;
  logic [15:0]         alu_a;
  logic [15:0]         alu_b;
  logic [2:0]          alu_znc_in;
  logic [15:0]         alu_a_res;
  logic [15:0]         alu_b_res;
  logic [2:0]          alu_znc;
  logic                res_valid;
  logic                res_ready = 1'b0;
  logic [15:0]         res_a;
  logic [15:0]         res_b;
  logic [2:0]          res_znc;
  logic                busy;

  int errors = 0;
  int checks = 0;
  logic [2:0] model_flags = 3'b000;

  always #5 clk = ~clk;

  // ALU stub: A+B into A, B passed through, flags from the sum.
  logic [16:0] w_sum;
  assign w_sum     = {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_a_res = w_sum[15:0];
  assign alu_b_res = alu_b;
  assign alu_znc   = {w_sum[15:0] == 16'h0000, w_sum[15], w_sum[16]};

  blue_sequencer #(.REPEAT_W(REPEAT_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_rpt(cmd_rpt),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_znc_in(alu_znc_in),
    .alu_a_res(alu_a_res), .alu_b_res(alu_b_res), .alu_znc(alu_znc),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_a(res_a), .res_b(res_b), .res_znc(res_znc), .busy(busy)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("%s", tag);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Final A is a+(rpt+1)*b; flags come from the last addition only.
  task automatic model(input logic [15:0] a, input logic [15:0] b, input int rpt,
                       output logic [15:0] ea, output logic [2:0] ef);
    logic [15:0] prev;
    logic [16:0] s;
    prev = 16'(int'(a) + rpt * int'(b));
    s    = {1'b0, prev} + {1'b0, b};
    ea   = s[15:0];
    ef   = {s[15:0] == 16'h0000, s[15], s[16]};
  endtask

  task automatic run_cmd(input logic [15:0] op, input logic [15:0] a, input logic [15:0] b,
                         input int rpt, input int hold);
    logic [15:0] ea;
    logic [2:0]  ef;
    int n;
    model(a, b, rpt, ea, ef);
    chk("ready_before_cmd", 16'(cmd_ready), 16'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_rpt = REPEAT_W'(rpt);
    step();
    cmd_valid = 1'b0; cmd_a = 16'($urandom); cmd_b = 16'($urandom);
    n = 1;
    chk("first_exec_flags_in", 16'(alu_znc_in), 16'(model_flags));
    chk("exec_alu_op", alu_op, op);
    while (res_valid !== 1'b1 && n < 40) begin
      chk("ready_low_exec", 16'(cmd_ready), 16'd0);
      cmd_valid = 1'($urandom);
      step();
      n++;
    end
    cmd_valid = 1'b0;
    chk("latency", 16'(n), 16'(rpt + 2));
    model_flags = ef;
    for (int d = 0; d <= hold; d++) begin
      chk("res_valid_done", 16'(res_valid), 16'd1);
      chk("ready_low_done", 16'(cmd_ready), 16'd0);
      chk("res_a", res_a, ea);
      chk("res_b", res_b, b);
      chk("res_znc", 16'(res_znc), 16'(ef));
      if (d < hold) begin
        cmd_valid = 1'($urandom);
        step();
      end
    end
    res_ready = 1'b1;
    cmd_valid = 1'b1;
    step();
    res_ready = 1'b0;
    cmd_valid = 1'b0;
    chk("idle_after_handoff", 16'(busy), 16'd0);
    chk("res_valid_idle", 16'(res_valid), 16'd0);
  endtask

  initial begin
    step();
    step();
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_ready", 16'(cmd_ready), 16'd1);
    chk("rst_res_valid", 16'(res_valid), 16'd0);
    chk("rst_res_a", res_a, 16'h0000);
    chk("rst_res_znc", 16'(res_znc), 16'd0);
    chk("rst_alu_op", alu_op, 16'h0000);
    rst = 1'b0;
    step();

    run_cmd(16'h0011, 16'h0001, 16'h0002, 0, 0);
    run_cmd(16'h0022, 16'h0001, 16'h0002, 3, 1);
    run_cmd(16'h0033, 16'hFFFF, 16'h0001, 0, 0);
    run_cmd(16'h0044, 16'h0000, 16'h0001, 15, 0);
    run_cmd(16'h0055, 16'h1234, 16'h0101, 2, 10);

    // Abort a 6-iteration command in its second EXEC cycle.
    cmd_valid = 1'b1; cmd_op = 16'h0066; cmd_a = 16'h0100; cmd_b = 16'h8001; cmd_rpt = 4'd5;
    step();
    cmd_valid = 1'b0;
    chk("abort_exec_c1", 16'(busy), 16'd1);
    step();
    rst = 1'b1;
    chk("abort_no_valid_c2", 16'(res_valid), 16'd0);
    step();
    rst = 1'b0;
    model_flags = 3'b000;
    chk("abort_busy", 16'(busy), 16'd0);
    chk("abort_ready", 16'(cmd_ready), 16'd1);
    chk("abort_alu_a", alu_a, 16'h0000);
    chk("abort_alu_b", alu_b, 16'h0000);
    chk("abort_alu_op", alu_op, 16'h0000);
    chk("abort_flags", 16'(alu_znc_in), 16'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("abort_no_result", 16'(res_valid), 16'd0);
    end

    run_cmd(16'h0077, 16'hFFFE, 16'h0001, 1, 0);

    for (int i = 0; i < 25; i++) begin
      run_cmd(16'($urandom), 16'($urandom), 16'($urandom),
              int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/blue_sequencer.md
BLUE_SEQUENCER -- requirements
Module: blue_sequencer

Interface
REQ-001 Parameter: REPEAT_W, default 4, width of the per-command repeat count.
REQ-002 Port: clk  input  1  single system clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: cmd_valid  input  1  command present.
REQ-005 Port: cmd_ready  output  1  sequencer accepts command this cycle.
REQ-006 Port: cmd_op  input  16  ALU opcode for the command.
REQ-007 Port: cmd_a  input  16  initial A operand.
REQ-008 Port: cmd_b  input  16  initial B operand.
REQ-009 Port: cmd_rpt  input  REPEAT_W  extra iterations; total iterations = cmd_rpt+1.
REQ-010 Port: alu_op  output  16  opcode to ALU.
REQ-011 Port: alu_a  output  16  A operand to ALU.
REQ-012 Port: alu_b  output  16  B operand to ALU.
REQ-013 Port: alu_znc_in  output  3  flag state to ALU, {Z,N,C}.
REQ-014 Port: alu_a_res  input  16  ALU A result.
REQ-015 Port: alu_b_res  input  16  ALU B result.
REQ-016 Port: alu_znc  input  3  ALU flag result {Z,N,C}.
REQ-017 Port: res_valid  output  1  result available.
REQ-018 Port: res_ready  input  1  consumer takes result.
REQ-019 Port: res_a  output  16  final A.
REQ-020 Port: res_b  output  16  final B.
REQ-021 Port: res_znc  output  3  final flags.
REQ-022 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-023 States SHALL be IDLE, EXEC, DONE; ALU is combinational, one iteration per clock.
REQ-024 IDLE: cmd_ready=1; cmd_valid&cmd_ready in cycle C captures op, a, b, rpt into working registers (op_r, a_r, b_r, cnt_r); next state EXEC.
REQ-025 cmd_ready SHALL be 0 in EXEC and DONE; cmd_valid there ignored, no state change.
REQ-026 alu_op=op_r, alu_a=a_r, alu_b=b_r, alu_znc_in=flags_r at all times; ALU outputs sampled only in EXEC.
REQ-027 Each EXEC cycle: a_r<=alu_a_res, b_r<=alu_b_res, flags_r<=alu_znc; if cnt_r==0 next DONE, else cnt_r<=cnt_r-1, stay EXEC.
REQ-028 Latency: EXEC occupies cycles C+1..C+1+cmd_rpt; res_valid first high in cycle C+cmd_rpt+2.
REQ-029 cmd_rpt=2^REPEAT_W-1 SHALL yield exactly 2^REPEAT_W iterations; cnt_r never wraps.
REQ-030 DONE: res_valid=1, res_a=a_r, res_b=b_r, res_znc=flags_r; held stable until res_ready sampled high, then next IDLE.
REQ-031 No accept in the cycle res_valid&res_ready completes; earliest next accept is the following cycle.
REQ-032 flags_r SHALL persist across commands (carry chaining); only rst clears it.
REQ-033 res_valid SHALL be 0 in IDLE and EXEC; res_a/res_b/res_znc undefined-free: always equal a_r/b_r/flags_r.

Reset
REQ-034 rst high at a clock edge SHALL force IDLE and clear op_r, a_r, b_r, cnt_r, flags_r to 0, from any state, including mid-EXEC; an aborted command produces no result.
REQ-035 After reset: cmd_ready=1, busy=0, res_valid=0, all 16/3-bit outputs 0; rst has priority over cmd_valid and res_ready.

Verification (bench ALU stub: a_res=a+b mod 2^16, b_res=b, Z=(a_res==0), N=a_res[15], C=carry-out)
REQ-036 a=0x0001, b=0x0002, rpt=0 accepted cycle C -> res_valid cycle C+2, res_a=0x0003, res_b=0x0002, res_znc=3'b000.
REQ-037 a=0x0001, b=0x0002, rpt=3 -> res_valid cycle C+5, res_a=0x0009; cmd_ready=0 cycles C+1..C+5.
REQ-038 a=0xFFFF, b=0x0001, rpt=0 -> res_a=0x0000, res_znc=3'b101; next command drives alu_znc_in=3'b101 during its first EXEC cycle.
REQ-039 a=0x0000, b=0x0001, rpt=15 (REPEAT_W=4) -> 16 iterations, res_a=0x0010, res_valid cycle C+17.
REQ-040 res_ready low 10 cycles in DONE -> res_valid and res_* unchanged, cmd_valid pulses ignored; res_ready high -> IDLE next cycle.
REQ-041 rst asserted in cycle C+2 of rpt=5 command -> IDLE at C+3, res_valid never asserted, all registers 0, flags_r=3'b000.
